// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// built from a single full-adder cell fed with a, ~b and an initial carry of 1.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  // state   | meaning
  // S_IDLE  | waiting for an operand pair, start_ready high
  // S_RUN   | shifting one bit per edge through the adder cell
  // S_DONE  | result held on diff/borrow_out until res_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] nb_sr_q;
  logic [WIDTH-1:0] res_sr_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             borrow_q;
  logic             res_valid_q;
  logic             busy_q;

  logic             sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] res_sr_d;

  always_comb begin
    sum_d    = a_sr_q[0] ^ nb_sr_q[0] ^ carry_q;
    carry_d  = (a_sr_q[0] & nb_sr_q[0]) | (a_sr_q[0] & carry_q) | (nb_sr_q[0] & carry_q);
    res_sr_d = {sum_d, res_sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sr_q      <= '0;
      nb_sr_q     <= '0;
      res_sr_q    <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            a_sr_q  <= a;
            nb_sr_q <= ~b;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          nb_sr_q  <= {1'b0, nb_sr_q[WIDTH-1:1]};
          carry_q  <= carry_d;
          res_sr_q <= res_sr_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            // no carry out of a + ~b + 1 means a < b
            diff_q      <= res_sr_d;
            borrow_q    <= ~carry_d;
            res_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign res_valid   = res_valid_q;
  assign diff        = diff_q;
  assign borrow_out  = borrow_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed results.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .diff        (diff),
    .borrow_out  (borrow_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after an edge with the block idle.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [W:0] exp, input int hold);
    int lat;
    logic [W:0] model;
    model       = {1'b0, ta} - {1'b0, tb_};
    check({tag, "_ready"}, 32'(start_ready), 32'd1);
    a           = ta;
    b           = tb_;
    res_ready   = (hold == 0);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    a           = ~ta;
    b           = ~tb_;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_result"}, 32'({borrow_out, diff}), 32'(exp));
    check({tag, "_model"}, 32'({borrow_out, diff}), 32'(model));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_hold_result"}, 32'({borrow_out, diff}), 32'(exp));
      check({tag, "_hold_ready"}, 32'(start_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    check({tag, "_release_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_release_ready"}, 32'(start_ready), 32'd1);
    check({tag, "_kept_result"}, 32'({borrow_out, diff}), 32'(exp));
    res_ready = 1'b0;
  endtask

  logic [W-1:0] pa [10] = '{8'h12, 8'h80, 8'h7F, 8'hC3, 8'h01, 8'hFF, 8'hA5, 8'h10, 8'h64, 8'h00};
  logic [W-1:0] pb [10] = '{8'h34, 8'h7F, 8'h80, 8'h3C, 8'h02, 8'hFF, 8'h5A, 8'hF0, 8'h32, 8'h01};
  logic [W:0]   pe [10] = '{9'h1DE, 9'h001, 9'h1FF, 9'h087, 9'h1FF, 9'h000, 9'h04B, 9'h120, 9'h032, 9'h1FF};

  initial begin
    int lat;
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0;
    #12;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(start_ready), 32'd1);
    rst = 1'b0;
    tick();

    do_op("basic",   8'h05, 8'h03, 9'h002, 0);
    do_op("under",   8'h03, 8'h05, 9'h1FE, 0);
    do_op("zero_ff", 8'h00, 8'hFF, 9'h101, 0);
    do_op("ff_one",  8'hFF, 8'h01, 9'h0FE, 0);
    do_op("zeros",   8'h00, 8'h00, 9'h000, 0);
    do_op("bp",      8'h03, 8'h05, 9'h1FE, 5);

    // inputs that must be ignored while an operation is in flight
    a = 8'h09; b = 8'h04; start_valid = 1'b1; res_ready = 1'b0;
    tick();
    a = 8'hAA; b = 8'h55;
    lat = 0;
    while (!res_valid && lat < 40) begin
      res_ready = ~res_ready;
      tick();
      lat++;
    end
    start_valid = 1'b0;
    res_ready   = 1'b0;
    check("ign_latency", 32'(lat), 32'(W));
    check("ign_result", 32'({borrow_out, diff}), 32'h005);
    tick();
    check("ign_hold_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int i = 0; i < W + 2; i++) tick();
    check("ign_no_second", 32'(res_valid), 32'd0);
    check("ign_idle_busy", 32'(busy), 32'd0);

    // reset while running
    a = 8'h40; b = 8'h01; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_borrow", 32'(borrow_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(start_ready), 32'd1);
    #7;
    rst = 1'b0;
    tick();
    do_op("after_rst", 8'h40, 8'h01, 9'h03F, 0);

    // back-to-back with start_valid held high
    res_ready   = 1'b1;
    start_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("b2b%0d_ready", k), 32'(start_ready), 32'd1);
      a = pa[k]; b = pb[k];
      tick();
      a = 8'h5A; b = 8'hC3;
      lat = 0;
      while (!res_valid && lat < 40) begin
        tick();
        lat++;
      end
      check($sformatf("b2b%0d_latency", k), 32'(lat), 32'(W));
      check($sformatf("b2b%0d_result", k), 32'({borrow_out, diff}), 32'(pe[k]));
      tick();
    end
    start_valid = 1'b0;
    res_ready   = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
